// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-stage types
package cpu_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_HOLD  = 2'd0,
    IFID_LOAD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_op_e;

  // J-type target keeps the region bits of the jump's own PC+4.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage control, ROM and IF/ID bundle
interface fetch_unit_if;

  logic                         stall;
  logic                         br_taken;
  logic [cpu_pkg::INSTR_W-1:0]  br_target;
  logic                         jmp_en;
  logic [25:0]                  jmp_index;
  logic [cpu_pkg::INSTR_W-1:0]  rom_data;
  logic [cpu_pkg::INSTR_W-1:0]  pc_addr;
  logic                         cs_rom;
  logic [cpu_pkg::INSTR_W-1:0]  ifid_instr;
  logic [cpu_pkg::INSTR_W-1:0]  ifid_pc4;
  logic                         ifid_valid;

  modport master (
    input  stall, br_taken, br_target, jmp_en, jmp_index, rom_data,
    output pc_addr, cs_rom, ifid_instr, ifid_pc4, ifid_valid
  );

  modport slave (
    output stall, br_taken, br_target, jmp_en, jmp_index, rom_data,
    input  pc_addr, cs_rom, ifid_instr, ifid_pc4, ifid_valid
  );

endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and flush
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  ifid_op_e     op_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc4_i,
  input  logic         valid_i,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc4_o,
  output logic         valid_o
);

  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc4_q, pc4_d;
  logic         valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (op_i)
      IFID_LOAD: begin
        instr_d = instr_i;
        pc4_d   = pc4_i;
        valid_d = valid_i;
      end
      IFID_FLUSH: begin
        instr_d = W'(NOP_INSTR);
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= W'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, next-PC select and ROM chip-select of the fetch stage
// Optional FETCH_PERF_CNT_EN adds fetch/stall/flush event counters.
module fetch_unit #(
  parameter int          INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int          ROM_BYTES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  import cpu_pkg::*;

  localparam logic [INSTR_W-1:0] ROM_LIMIT = INSTR_W'(ROM_BYTES);

  logic               run_q;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] pc4;
  logic [INSTR_W-1:0] jmp_tgt;
  logic               cs_rom;
  logic               redirect;
  pc_sel_e            pc_sel;
  ifid_op_e           ifid_op;
  logic [INSTR_W-1:0] load_instr;

  assign pc4      = pc_q + INSTR_W'(PC_INCR);
  assign jmp_tgt  = jump_target(bus.ifid_pc4, bus.jmp_index);
  assign redirect = bus.br_taken | bus.jmp_en;
  assign cs_rom   = run_q & (pc_q < ROM_LIMIT) & (pc_q[1:0] == 2'b00);

  // The first edge after reset release only arms run; nothing moves yet.
  always_comb begin
    pc_sel  = PC_HOLD;
    ifid_op = IFID_HOLD;
    if (run_q) begin
      if (bus.br_taken) begin
        pc_sel  = PC_BRANCH;
        ifid_op = IFID_FLUSH;
      end else if (bus.jmp_en) begin
        pc_sel  = PC_JUMP;
        ifid_op = IFID_FLUSH;
      end else if (bus.stall) begin
        pc_sel  = PC_HOLD;
        ifid_op = IFID_HOLD;
      end else begin
        pc_sel  = PC_SEQ;
        ifid_op = IFID_LOAD;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_SEQ:    pc_d = pc4;
      PC_BRANCH: pc_d = bus.br_target;
      PC_JUMP:   pc_d = jmp_tgt;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      pc_q  <= INSTR_W'(RESET_PC);
    end else begin
      run_q <= 1'b1;
      pc_q  <= pc_d;
    end
  end

  // Unselected ROM output is never trusted; a bubble carries a NOP.
  assign load_instr = cs_rom ? bus.rom_data : INSTR_W'(NOP_INSTR);

  ifid_reg #(
    .W (INSTR_W)
  ) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .op_i    (ifid_op),
    .instr_i (load_instr),
    .pc4_i   (pc4),
    .valid_i (cs_rom),
    .instr_o (bus.ifid_instr),
    .pc4_o   (bus.ifid_pc4),
    .valid_o (bus.ifid_valid)
  );

  assign bus.pc_addr = pc_q;
  assign bus.cs_rom  = cs_rom;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ifid_op == IFID_LOAD && cs_rom) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (run_q && bus.stall && !redirect) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_op == IFID_FLUSH) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  fetch_unit #(
    .INSTR_W   (32),
    .RESET_PC  (32'h0000_0000),
    .ROM_BYTES (256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Program image; every other word is distinct junk so NOP gating is visible.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h00: return 32'h2001_0008;
      32'h04: return 32'h3402_000c;
      32'h24: return 32'h1022_0002;
      32'h34: return 32'had02_000a;
      default: return 32'hC000_0001 | w;
    endcase
  endfunction

  always_comb bus.rom_data = rom_word(bus.pc_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        m_run;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
  endtask

  function automatic logic model_cs();
    return m_run && (m_pc < 32'd256) && (m_pc % 4 == 0);
  endfunction

  task automatic model_step(input logic st, input logic br, input logic [31:0] bt,
                            input logic jp, input logic [25:0] ji);
    logic cs;
    cs = model_cs();
    if (!m_run) m_run = 1;
    else if (br || jp) begin
      m_pc    = br ? bt : ((m_pc4 & 32'hF000_0000) + ({6'b0, ji} * 4));
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (!st) begin
      m_instr = cs ? rom_word(m_pc) : 32'h0;
      m_pc4   = m_pc + 4;
      m_valid = cs;
      m_pc    = m_pc + 4;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    bus.pc_addr,           m_pc);
    chk({tag, ".cs"},    {31'b0, bus.cs_rom},   {31'b0, model_cs()});
    chk({tag, ".instr"}, bus.ifid_instr,        m_instr);
    chk({tag, ".pc4"},   bus.ifid_pc4,          m_pc4);
    chk({tag, ".valid"}, {31'b0, bus.ifid_valid}, {31'b0, m_valid});
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [25:0] ji);
    bus.stall = st; bus.br_taken = br; bus.br_target = bt;
    bus.jmp_en = jp; bus.jmp_index = ji;
  endtask

  task automatic step(input string tag, input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [25:0] ji);
    drive(st, br, bt, jp, ji);
    model_step(st, br, bt, jp, ji);
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    #2;
    model_reset();
    check_model(tag);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  typedef struct {
    logic        stall, br;
    logic [31:0] bt;
    logic        jmp;
    logic [25:0] ji;
    logic [31:0] pc;
    logic        cs;
    logic [31:0] instr, pc4;
    logic        valid;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [25:0] ji, input logic [31:0] pc,
                              input logic cs, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
    vec_t v;
    v.stall = st; v.br = br; v.bt = bt; v.jmp = jp; v.ji = ji;
    v.pc = pc; v.cs = cs; v.instr = instr; v.pc4 = pc4; v.valid = valid;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    drive(0, 0, 0, 0, 0);

    tbl[0]  = mk(0, 0, 0,     0, 0,     32'h04,  1, 32'h2001_0008,     32'h04,  1);
    tbl[1]  = mk(0, 0, 0,     0, 0,     32'h08,  1, 32'h3402_000c,     32'h08,  1);
    tbl[2]  = mk(0, 0, 0,     0, 0,     32'h0C,  1, rom_word(32'h08),  32'h0C,  1);
    tbl[3]  = mk(1, 0, 0,     0, 0,     32'h0C,  1, rom_word(32'h08),  32'h0C,  1);
    tbl[4]  = mk(1, 0, 0,     0, 0,     32'h0C,  1, rom_word(32'h08),  32'h0C,  1);
    tbl[5]  = mk(0, 0, 0,     0, 0,     32'h10,  1, rom_word(32'h0C),  32'h10,  1);
    tbl[6]  = mk(0, 0, 0,     0, 0,     32'h14,  1, rom_word(32'h10),  32'h14,  1);
    tbl[7]  = mk(0, 0, 0,     0, 0,     32'h18,  1, rom_word(32'h14),  32'h18,  1);
    tbl[8]  = mk(0, 0, 0,     0, 0,     32'h1C,  1, rom_word(32'h18),  32'h1C,  1);
    tbl[9]  = mk(0, 0, 0,     0, 0,     32'h20,  1, rom_word(32'h1C),  32'h20,  1);
    tbl[10] = mk(0, 1, 32'h24, 0, 0,    32'h24,  1, 32'h0,             32'h0,   0);
    tbl[11] = mk(0, 0, 0,     0, 0,     32'h28,  1, 32'h1022_0002,     32'h28,  1);
    tbl[12] = mk(0, 0, 0,     0, 0,     32'h2C,  1, rom_word(32'h28),  32'h2C,  1);
    tbl[13] = mk(0, 0, 0,     1, 26'hd, 32'h34,  1, 32'h0,             32'h0,   0);
    tbl[14] = mk(0, 0, 0,     0, 0,     32'h38,  1, 32'had02_000a,     32'h38,  1);
    tbl[15] = mk(1, 1, 32'h48, 1, 26'hd, 32'h48, 1, 32'h0,             32'h0,   0);
    tbl[16] = mk(0, 0, 0,     0, 0,     32'h4C,  1, rom_word(32'h48),  32'h4C,  1);
    tbl[17] = mk(0, 1, 32'h100, 0, 0,   32'h100, 0, 32'h0,             32'h0,   0);
    tbl[18] = mk(0, 0, 0,     0, 0,     32'h104, 0, 32'h0,             32'h104, 0);
    tbl[19] = mk(0, 0, 0,     0, 0,     32'h108, 0, 32'h0,             32'h108, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc",    bus.pc_addr,    32'h0);
    chk("rst.cs",    {31'b0, bus.cs_rom}, 32'h0);
    chk("rst.instr", bus.ifid_instr, 32'h0);
    chk("rst.pc4",   bus.ifid_pc4,   32'h0);
    chk("rst.valid", {31'b0, bus.ifid_valid}, 32'h0);

    rst_n = 1;
    @(posedge clk); #1;
    chk("arm.pc",    bus.pc_addr,    32'h0);
    chk("arm.cs",    {31'b0, bus.cs_rom}, 32'h1);
    chk("arm.valid", {31'b0, bus.ifid_valid}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].ji);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.pc", i),    bus.pc_addr,    tbl[i].pc);
      chk($sformatf("vec%0d.cs", i),    {31'b0, bus.cs_rom}, {31'b0, tbl[i].cs});
      chk($sformatf("vec%0d.instr", i), bus.ifid_instr, tbl[i].instr);
      chk($sformatf("vec%0d.pc4", i),   bus.ifid_pc4,   tbl[i].pc4);
      chk($sformatf("vec%0d.valid", i), {31'b0, bus.ifid_valid}, {31'b0, tbl[i].valid});
    end

    // Reset mid-stream with a branch pending: the branch must be forgotten.
    drive(0, 1, 32'h80, 0, 0);
    do_reset("midrst");
    step("hold_after_rst", 0, 0, 0, 0, 0);
    chk("hold_after_rst.pc_const", bus.pc_addr, 32'h0);
    step("first_fetch", 0, 0, 0, 0, 0);
    chk("first_fetch.instr_const", bus.ifid_instr, 32'h2001_0008);

    // Misaligned redirect: PC keeps advancing, only bubbles come out.
    step("mis0", 0, 1, 32'h42, 0, 0);
    step("mis1", 0, 0, 0, 0, 0);
    step("mis2", 1, 0, 0, 0, 0);
    step("mis3", 0, 0, 0, 0, 0);
    chk("mis3.pc_const", bus.pc_addr, 32'h4A);

    // Upper region bits of ifid_pc4 must flow into the jump target.
    step("hi0", 0, 1, 32'h1000_0000, 0, 0);
    step("hi1", 0, 0, 0, 0, 0);
    step("hi2", 0, 0, 0, 1, 26'h5);
    chk("hi2.pc_const", bus.pc_addr, 32'h1000_0014);

    do_reset("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      logic        st, br, jp;
      logic [31:0] bt;
      logic [25:0] ji;
      if ($urandom_range(0, 79) == 0) begin
        do_reset($sformatf("rnd%0d.rst", i));
      end else begin
        st = ($urandom_range(0, 3) == 0);
        br = ($urandom_range(0, 7) == 0);
        jp = ($urandom_range(0, 7) == 0);
        bt = 32'($urandom_range(0, 71)) * 4;
        if ($urandom_range(0, 9) == 0) bt = bt + 32'd2;
        if ($urandom_range(0, 19) == 0) bt = 32'h1000_0000 | bt;
        ji = 26'($urandom_range(0, 71));
        step($sformatf("rnd%0d", i), st, br, bt, jp, ji);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
